// File: rtl/branch_pred_bht.sv
// Branch history table of 2-bit saturating counters with mispredict flagging.
// Optional `BP_STATS_EN adds resolved-branch and mispredict counters.
module branch_pred_bht #(
    parameter int         PC_W    = 32,
    parameter int         IDX_W   = 4,
    parameter logic [1:0] INIT_ST = 2'b01,
    parameter int         STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pred_pcsrc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              act_pcsrc,
    input  logic              upd_pred,
    output logic              mispredict,
    output logic              recover_sel
`ifdef BP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_miss
`endif
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       cnt [DEPTH];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       cur_cnt;
    logic [1:0]       nxt_cnt;
    logic             mis_d;
    logic             rec_d;
    logic             unused_pc_bits;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];

    // Word-aligned PCs with no tag: offset and upper bits never matter.
    assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    // Lookup reads the table directly; same-cycle updates are not bypassed.
    assign pred_pcsrc = cnt[lk_idx][1];

    // Saturating step of the counter being trained.
    always_comb begin
        cur_cnt = cnt[upd_idx];
        nxt_cnt = cur_cnt;
        if (act_pcsrc) begin
            if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'd1;
        end
    end

    // Mispredict condition and the matching recovery select.
    always_comb begin
        mis_d = upd_valid & (act_pcsrc ^ upd_pred);
        rec_d = upd_valid & ~act_pcsrc & upd_pred;
    end

    // Counter table: reset to INIT_ST, trained by resolved branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= INIT_ST;
        end else if (upd_valid) begin
            cnt[upd_idx] <= nxt_cnt;
        end
    end

    // Registered one-cycle mispredict pulse and recovery select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            recover_sel <= 1'b0;
        end else begin
            mispredict  <= mis_d;
            recover_sel <= rec_d;
        end
    end

`ifdef BP_STATS_EN
    // Free-running statistics; wrap naturally at 2**STAT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br   <= '0;
            stat_miss <= '0;
        end else begin
            if (upd_valid) stat_br   <= stat_br + 1'b1;
            if (mis_d)     stat_miss <= stat_miss + 1'b1;
        end
    end
`endif

endmodule
